// File: rtl/gpio_in_capture.sv
// gpio_in_capture
// Avalon-MM GPIO input peripheral. Each of the WIDTH external inputs is
// synchronised and can optionally be debounced. Selected edges of the
// accepted level are latched into a sticky, write-1-to-clear capture
// register, and a level interrupt is raised while any captured bit is unmasked.
//
// Register map (word addresses):
//   0 : data         (read: debounced input level; writes ignored)
//   1 : reserved     (reads 0; writes ignored)
//   2 : irq mask     (read/write)
//   3 : edge capture (read; write 1 to clear)
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset_n    asynchronous active-low reset
//   address    register select
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data
//   in_port    asynchronous external inputs
//   readdata   registered read data, zero-extended to 32 bits
//   irq        level interrupt, active high
module gpio_in_capture #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // A bypassed debouncer still needs a counter to compare against; a
    // single bit that never leaves zero keeps the accept path uniform.
    localparam int              CNT_W   = (DEBOUNCE_CYCLES == 0) ? 1 : 16;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_deb_d;
    logic [CNT_W-1:0] r_cnt  [WIDTH];
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_mask;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_sync_out;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_wr       = chipselect && !write_n;
    // Upper writedata bits are unused when WIDTH < 32.
    assign w_unused   = ^writedata;

    // Synchroniser chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Debounce: a changed level is accepted only after it has disagreed
    // with the current accepted level for DEBOUNCE_CYCLES+1 consecutive
    // cycles; any agreement in between restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_sync_out[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_deb[i] <= w_sync_out[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Edge detect on the accepted level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_d <= '0;
        end else begin
            r_deb_d <= r_deb;
        end
    end

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign w_edge = r_deb & ~r_deb_d;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign w_edge = ~r_deb & r_deb_d;
        end else begin : g_any
            assign w_edge = r_deb ^ r_deb_d;
        end
    endgenerate

    // Edge capture: the clear is applied first so a coincident edge wins.
    assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap <= '0;
        end else begin
            r_cap <= (r_cap & ~w_clr) | w_edge;
        end
    end

    // Interrupt mask
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
        end else if (w_wr && address == 2'd2) begin
            r_mask <= writedata[WIDTH-1:0];
        end
    end

    // Read mux, registered every cycle independent of chipselect
    always_comb begin
        w_rd_mux = '0;
        case (address)
            2'd0:    w_rd_mux[WIDTH-1:0] = r_deb;
            2'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
            2'd3:    w_rd_mux[WIDTH-1:0] = r_cap;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_gpio_in_capture.sv
// Self-checking bench for gpio_in_capture. Three instances share one clock:
//   A: defaults (WIDTH=8, no debounce, rising edges)
//   B: DEBOUNCE_CYCLES=3
//   C: WIDTH=32, EDGE_TYPE=2 (any edge)
module tb_gpio_in_capture;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, rst_c;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic        cs_a, cs_b, cs_c;
    logic [7:0]  in_a, in_b;
    logic [31:0] in_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;

    int n_cmp = 0;
    int n_bad = 0;

    gpio_in_capture u_a (
        .clk(clk), .reset_n(rst_a), .address(address), .chipselect(cs_a),
        .write_n(write_n), .writedata(writedata), .in_port(in_a),
        .readdata(rd_a), .irq(irq_a)
    );

    gpio_in_capture #(.DEBOUNCE_CYCLES(3)) u_b (
        .clk(clk), .reset_n(rst_b), .address(address), .chipselect(cs_b),
        .write_n(write_n), .writedata(writedata), .in_port(in_b),
        .readdata(rd_b), .irq(irq_b)
    );

    gpio_in_capture #(.WIDTH(32), .EDGE_TYPE(2)) u_c (
        .clk(clk), .reset_n(rst_c), .address(address), .chipselect(cs_c),
        .write_n(write_n), .writedata(writedata), .in_port(in_c),
        .readdata(rd_c), .irq(irq_c)
    );

    typedef struct {
        logic [7:0]  in_val;
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic do_write(input int which, input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        cs_a      = (which == 0);
        cs_b      = (which == 1);
        cs_c      = (which == 2);
        tick();
        cs_a      = 1'b0;
        cs_b      = 1'b0;
        cs_c      = 1'b0;
        write_n   = 1'b1;
        writedata = '0;
    endtask

    initial begin
        // in, addr, wr, wdata, expected readdata, expected irq
        vecs[0]  = '{8'h5A, 2'd0, 1'b0, 32'h0,        32'h00, 1'b0};
        vecs[1]  = '{8'h5A, 2'd0, 1'b0, 32'h0,        32'h00, 1'b0};
        vecs[2]  = '{8'h5A, 2'd0, 1'b0, 32'h0,        32'h00, 1'b0};  // E+2: not yet
        vecs[3]  = '{8'h5A, 2'd0, 1'b0, 32'h0,        32'h5A, 1'b0};  // E+3: level visible
        vecs[4]  = '{8'h5A, 2'd3, 1'b0, 32'h0,        32'h5A, 1'b0};  // cap set
        vecs[5]  = '{8'h5A, 2'd2, 1'b1, 32'h02,       32'h00, 1'b1};  // mask write
        vecs[6]  = '{8'h5A, 2'd2, 1'b0, 32'h0,        32'h02, 1'b1};
        vecs[7]  = '{8'h5A, 2'd3, 1'b1, 32'h02,       32'h5A, 1'b0};  // W1C bit 1
        vecs[8]  = '{8'h5A, 2'd3, 1'b0, 32'h0,        32'h58, 1'b0};
        vecs[9]  = '{8'h5A, 2'd0, 1'b1, 32'hFFFFFFFF, 32'h5A, 1'b0};  // data write ignored
        vecs[10] = '{8'h5A, 2'd0, 1'b0, 32'h0,        32'h5A, 1'b0};
        vecs[11] = '{8'h5A, 2'd1, 1'b0, 32'h0,        32'h00, 1'b0};
        vecs[12] = '{8'h5A, 2'd2, 1'b1, 32'hFF,       32'h02, 1'b1};
        vecs[13] = '{8'h5A, 2'd3, 1'b0, 32'h0,        32'h58, 1'b1};

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        address = 2'd0; write_n = 1'b1; writedata = '0;
        cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0;
        in_a = 8'hFF; in_b = 8'h00; in_c = 32'h0;

        // ---- Reset with inputs high ----
        tick(); tick(); tick();
        check("a_reset_readdata", rd_a, 32'h0);
        check("a_reset_irq", {31'b0, irq_a}, 32'h0);

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        address = 2'd3;
        for (int k = 0; k < 5; k++) tick();
        check("a_cap_after_reset_release", rd_a, 32'hFF);

        // Clear, drop inputs; falling edges are not captured in rising mode
        in_a = 8'h00;
        do_write(0, 2'd3, 32'hFF);
        for (int k = 0; k < 4; k++) tick();
        address = 2'd3;
        tick();
        check("a_cap_after_fall", rd_a, 32'h0);

        // ---- Table: latency, mask, W1C, ignored writes ----
        for (int i = 0; i < 14; i++) begin
            in_a      = vecs[i].in_val;
            address   = vecs[i].addr;
            writedata = vecs[i].wdata;
            write_n   = ~vecs[i].wr;
            cs_a      = vecs[i].wr;
            tick();
            check($sformatf("a_vec%0d_readdata", i), rd_a, vecs[i].exp_rd);
            check($sformatf("a_vec%0d_irq", i), {31'b0, irq_a}, {31'b0, vecs[i].exp_irq});
        end
        cs_a = 1'b0; write_n = 1'b1; writedata = '0;

        // ---- Set/clear collision on bit 0 (bit 3 cleared normally) ----
        in_a = 8'h5B;
        address = 2'd0;
        tick(); tick(); tick();
        do_write(0, 2'd3, 32'h09);
        address = 2'd3;
        tick();
        check("a_collision_cap", rd_a, 32'h51);
        check("a_collision_irq", {31'b0, irq_a}, 32'h1);

        // ---- Debounce: 3-cycle pulse must be rejected ----
        in_b = 8'h80;
        address = 2'd0;
        tick(); tick(); tick();
        in_b = 8'h00;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("b_pulse3_deb_c%0d", k), rd_b, 32'h0);
        end
        address = 2'd3;
        tick();
        check("b_pulse3_cap", rd_b, 32'h0);

        // ---- Debounce: 4-cycle pulse accepted, exact latency ----
        address = 2'd0;
        in_b = 8'h80;
        tick(); tick(); tick(); tick();
        in_b = 8'h00;
        tick();
        tick();
        check("b_pulse4_deb_E+5", rd_b, 32'h0);
        tick();
        check("b_pulse4_deb_E+6", rd_b, 32'h80);
        for (int k = 0; k < 6; k++) tick();
        address = 2'd3;
        tick();
        check("b_pulse4_cap", rd_b, 32'h80);
        do_write(1, 2'd2, 32'h80);
        check("b_irq_masked", {31'b0, irq_b}, 32'h1);

        // ---- Reset asserted mid-pulse ----
        address = 2'd3;
        in_b = 8'h80;
        tick(); tick();
        rst_b = 1'b0;
        #1;
        check("b_midreset_readdata", rd_b, 32'h0);
        check("b_midreset_irq", {31'b0, irq_b}, 32'h0);
        tick(); tick();
        in_b = 8'h00;
        rst_b = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("b_after_reset_cap", rd_b, 32'h0);
        address = 2'd0;
        tick();
        check("b_after_reset_deb", rd_b, 32'h0);
        address = 2'd2;
        tick();
        check("b_after_reset_mask", rd_b, 32'h0);

        // ---- Any-edge, 32 bits ----
        in_c = 32'hFFFFFFFF;
        address = 2'd3;
        for (int k = 0; k < 5; k++) tick();
        check("c_cap_rise", rd_c, 32'hFFFFFFFF);
        do_write(2, 2'd3, 32'hFFFFFFFF);
        address = 2'd3;
        tick();
        check("c_cap_cleared", rd_c, 32'h0);
        in_c = 32'h0;
        for (int k = 0; k < 5; k++) tick();
        check("c_cap_fall", rd_c, 32'hFFFFFFFF);
        address = 2'd1;
        tick();
        check("c_reserved", rd_c, 32'h0);
        address = 2'd0;
        tick();
        check("c_deb_low", rd_c, 32'h0);
        do_write(2, 2'd2, 32'h80000000);
        check("c_irq_msb", {31'b0, irq_c}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
